pcie_tx_arb: RTL and testbench
==============================

PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 Parameter NWR, 2, number of write-request channels (1..4).
REQ-002 Parameter RR_LEN_DW, 128, read-request length in DW (1..1024; 1024 encodes as 0).
REQ-003 Parameter FIFO_AW, 9, output FIFO address width (depth 2^FIFO_AW beats of 66 bits).
REQ-004 clock  in  1  all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 pcie_id  in  16  requester/completer ID.
REQ-007 rc_done  in  1  single-cycle pulse: completion data ready.
REQ-008 rc_dw2  in  32  completion header DW2.
REQ-009 rc_data  in  32  completion payload, host byte order.
REQ-010 rr_valid  in  1  read request pending.
REQ-011 rr_addr  in  64  read address.
REQ-012 rr_tag  in  8  read tag.
REQ-013 rr_ready  out  1  read request consumed this cycle.
REQ-014 wr_valid  in  NWR  per-channel write packet pending.
REQ-015 wr_ready  out  NWR  per-channel beat accept strobe.
REQ-016 wr_data  in  66*NWR  per-channel beat {1dw, last, data[63:0]}, channel k at bits 66k+65:66k.
REQ-017 tx_tready  in  1  AXI-S sink ready.
REQ-018 tx_tdata  out  64  AXI-S data.
REQ-019 tx_1dw  out  1  upper DW of beat invalid.
REQ-020 tx_tlast  out  1  last beat of TLP.
REQ-021 tx_tvalid  out  1  AXI-S valid.
REQ-022 stat_tlps  out  32  TLPs written into output FIFO (see Configuration).

Function
REQ-023 States IDLE, RC_HDR, RC_DAT, RR_HDR, RR_ADR, WR; arbitration only in IDLE, RC_DAT, RR_ADR, or WR on a beat with last=1.
REQ-024 Arbitration requires FIFO free space >= 2 beats; priority pending completion > rr_valid > write channels round-robin; nothing eligible -> IDLE.
REQ-025 Round-robin pointer starts at channel 0; after channel k's last beat it points to k+1 mod NWR; search begins at pointer.
REQ-026 rc_done sets a sticky pending flag cleared in RC_DAT; rc_done coincident with clear leaves flag set.
REQ-027 RC_HDR beat = {1dw=0, last=0, pcie_id, 16'd8, 32'h4A000001}.
REQ-028 RC_DAT beat = {1dw=0, last=1, byte-swapped rc_data, rc_dw2}; byte swap reverses the 4 bytes.
REQ-029 RR_HDR beat = {0, 0, pcie_id, rr_tag, 8'hFF, 2'b00, ~is32, 19'd0, RR_LEN_DW[9:0]}; is32 = rr_addr[63:32]==0.
REQ-030 RR_ADR beat: is32 -> {1, 1, rr_addr[31:0], rr_addr[31:0]}; else {0, 1, rr_addr[31:0], rr_addr[63:32]}; rr_ready=1 only in RR_ADR.
REQ-031 WR: wr_ready[k]=1 for granted channel k only while FIFO free space >= 2; each accepted beat copied verbatim; stall mid-packet holds state WR.
REQ-032 A beat reaches the FIFO one cycle after its state; with empty FIFO tx_tvalid rises two cycles after entering the header state.
REQ-033 Output is first-word-fall-through; beat pops when tx_tvalid & tx_tready; beat order preserved; no TLP interleaving.
REQ-034 FIFO full never drops beats; FIFO empty -> tx_tvalid=0.

Reset
REQ-035 Reset: state IDLE, pending flag 0, RR pointer 0, FIFO emptied, stat_tlps 0, tx_tvalid/rr_ready/wr_ready 0 the next cycle.
REQ-036 Reset mid-TLP discards the partial TLP; no partial TLP is emitted after reset.

Configuration
REQ-037 PCIE_TX_ARB_STATS_EN defined: stat_tlps increments (wrapping) once per last beat written into FIFO.
REQ-038 PCIE_TX_ARB_STATS_EN undefined: stat_tlps is constant 0 and the counter is not synthesised.

Verification
REQ-039 rc_done, rc_data=32'h11223344, rc_dw2=32'hA5 -> beats ..._4A000001 then {44332211,000000A5}, tlast=1.
REQ-040 rr_addr=64'h1000, tag 3 -> header bit29=0, len 128; second beat tx_1dw=1, tlast=1, data {1000,1000}.
REQ-041 rr_addr=64'h1_0000_2000 -> header bit29=1; second beat data {00002000,00000001}, tx_1dw=0.
REQ-042 NWR=2, both channels stream 3-beat packets -> grants alternate 0,1,0,1; no interleaved beats.
REQ-043 rc_done, rr_valid, wr_valid all in one cycle -> completion, then read, then write TLP.
REQ-044 tx_tready=0 until FIFO fills during a write -> wr_ready drops at free<2, no loss, all beats appear in order after release.

Source files
------------

// File: rtl/pcie_tx_arb.sv
// PCIe transmit arbiter: merges completions, read requests and NWR write channels into one 66-bit beat FIFO feeding an AXI-S sink.
// Optional TLP counter on stat_tlps is built only when PCIE_TX_ARB_STATS_EN is defined.
module pcie_tx_arb #(
  parameter int NWR       = 2,
  parameter int RR_LEN_DW = 128,
  parameter int FIFO_AW   = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       pcie_id,
  input  logic              rc_done,
  input  logic [31:0]       rc_dw2,
  input  logic [31:0]       rc_data,
  input  logic              rr_valid,
  input  logic [63:0]       rr_addr,
  input  logic [7:0]        rr_tag,
  output logic              rr_ready,
  input  logic [NWR-1:0]    wr_valid,
  output logic [NWR-1:0]    wr_ready,
  input  logic [66*NWR-1:0] wr_data,
  input  logic              tx_tready,
  output logic [63:0]       tx_tdata,
  output logic              tx_1dw,
  output logic              tx_tlast,
  output logic              tx_tvalid,
  output logic [31:0]       stat_tlps,
  output logic [2:0]        dbg_state
);

  // Handshakes: a beat moves when valid and ready are both high at a rising edge;
  // ready never depends combinationally on the matching valid.

  localparam int GW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [9:0] RR_LEN = 10'(RR_LEN_DW);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RC_HDR = 3'd1,
    S_RC_DAT = 3'd2,
    S_RR_HDR = 3'd3,
    S_RR_ADR = 3'd4,
    S_WR     = 3'd5
  } state_t;

  state_t          state, state_n, arb_state;
  logic [GW-1:0]   gnt, gnt_n, arb_gnt;
  logic [GW-1:0]   rr_ptr, rr_ptr_n, ptr_inc, search_start, wr_pick, cand;
  logic            rc_pend, rc_clr, rc_elig, rr_elig, wr_any;
  logic [NWR-1:0]  wr_mask;
  logic [65:0]     wr_beat [NWR];
  logic [65:0]     cur_beat;
  logic            accept_last;
  logic            emit;
  logic [65:0]     beat;
  logic            pipe_v;
  logic [65:0]     pipe_d;
  logic [65:0]     mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, free;
  logic            space_ok, fifo_pop, is32;

  for (genvar k = 0; k < NWR; k++) begin : g_unpack
    assign wr_beat[k] = wr_data[66*k +: 66];
  end

  assign cur_beat = wr_beat[gnt];
  assign is32     = (rr_addr[63:32] == 32'd0);
  assign dbg_state = state;

  // Free space counts the beat still in the pipeline register as already used.
  assign free     = DEPTH_L - count - {{FIFO_AW{1'b0}}, pipe_v};
  assign space_ok = (free >= (FIFO_AW+1)'(2));

  always_comb begin
    ptr_inc = gnt + GW'(1);
    if (int'(gnt) == NWR - 1) ptr_inc = '0;
  end

  assign accept_last  = (state == S_WR) && space_ok && wr_valid[gnt] && cur_beat[64];
  assign search_start = (state == S_WR) ? ptr_inc : rr_ptr;
  // A completion or read request being finished this cycle must not re-win arbitration.
  assign rc_elig = (state == S_RC_DAT) ? rc_done : (rc_pend | rc_done);
  assign rr_elig = rr_valid && (state != S_RR_ADR);

  always_comb begin
    wr_mask = wr_valid;
    if (accept_last) wr_mask[gnt] = 1'b0;
  end

  // Round-robin search: nearest valid channel at or after search_start wins.
  always_comb begin
    wr_any  = 1'b0;
    wr_pick = '0;
    cand    = '0;
    for (int i = NWR - 1; i >= 0; i--) begin
      cand = GW'((int'(search_start) + i) % NWR);
      if (wr_mask[cand]) begin
        wr_any  = 1'b1;
        wr_pick = cand;
      end
    end
  end

  always_comb begin
    arb_state = S_IDLE;
    arb_gnt   = gnt;
    if (space_ok) begin
      if (rc_elig) begin
        arb_state = S_RC_HDR;
      end else if (rr_elig) begin
        arb_state = S_RR_HDR;
      end else if (wr_any) begin
        arb_state = S_WR;
        arb_gnt   = wr_pick;
      end
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    rr_ptr_n = rr_ptr;
    emit     = 1'b0;
    beat     = '0;
    rr_ready = 1'b0;
    wr_ready = '0;
    rc_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = arb_state;
        gnt_n   = arb_gnt;
      end
      S_RC_HDR: begin
        if (space_ok) begin
          emit    = 1'b1;
          beat    = {1'b0, 1'b0, pcie_id, 16'd8, 32'h4A000001};
          state_n = S_RC_DAT;
        end
      end
      S_RC_DAT: begin
        if (space_ok) begin
          emit    = 1'b1;
          beat    = {1'b0, 1'b1, rc_data[7:0], rc_data[15:8], rc_data[23:16],
                     rc_data[31:24], rc_dw2};
          rc_clr  = 1'b1;
          state_n = arb_state;
          gnt_n   = arb_gnt;
        end
      end
      S_RR_HDR: begin
        if (space_ok) begin
          emit    = 1'b1;
          beat    = {1'b0, 1'b0, pcie_id, rr_tag, 8'hFF, 2'b00, ~is32, 19'd0, RR_LEN};
          state_n = S_RR_ADR;
        end
      end
      S_RR_ADR: begin
        if (space_ok) begin
          emit     = 1'b1;
          beat     = is32 ? {1'b1, 1'b1, rr_addr[31:0], rr_addr[31:0]}
                          : {1'b0, 1'b1, rr_addr[31:0], rr_addr[63:32]};
          rr_ready = 1'b1;
          state_n  = arb_state;
          gnt_n    = arb_gnt;
        end
      end
      S_WR: begin
        wr_ready[gnt] = space_ok;
        if (space_ok && wr_valid[gnt]) begin
          emit = 1'b1;
          beat = cur_beat;
          if (cur_beat[64]) begin
            rr_ptr_n = ptr_inc;
            state_n  = arb_state;
            gnt_n    = arb_gnt;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      rc_pend <= 1'b0;
      pipe_v  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      rr_ptr  <= rr_ptr_n;
      rc_pend <= rc_done | (rc_pend & ~rc_clr);
      pipe_v  <= emit;
    end
  end

  always_ff @(posedge clock) begin
    pipe_d <= beat;
  end

  // First-word-fall-through beat FIFO; overflow is prevented by the space check upstream.
  assign fifo_pop  = tx_tvalid & tx_tready;
  assign tx_tvalid = (count != '0);
  assign tx_1dw    = mem[rd_ptr][65];
  assign tx_tlast  = mem[rd_ptr][64];
  assign tx_tdata  = mem[rd_ptr][63:0];

  always_ff @(posedge clock) begin
    if (pipe_v) mem[wr_ptr] <= pipe_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pipe_v)   wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + {{FIFO_AW{1'b0}}, pipe_v} - {{FIFO_AW{1'b0}}, fifo_pop};
    end
  end

`ifdef PCIE_TX_ARB_STATS_EN
  logic [31:0] tlp_cnt;
  always_ff @(posedge clock) begin
    if (reset)                   tlp_cnt <= '0;
    else if (pipe_v & pipe_d[64]) tlp_cnt <= tlp_cnt + 32'd1;
  end
  assign stat_tlps = tlp_cnt;
`else
  assign stat_tlps = '0;
`endif

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Bench for pcie_tx_arb: random completions, reads and write packets checked against an ordering model.
module tb_pcie_tx_arb;
  localparam int NWR = 2;
  localparam int FIFO_AW = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [15:0]       pcie_id;
  logic              rc_done;
  logic [31:0]       rc_dw2, rc_data;
  logic              rr_valid;
  logic [63:0]       rr_addr;
  logic [7:0]        rr_tag;
  logic              rr_ready;
  logic [NWR-1:0]    wr_valid;
  logic [NWR-1:0]    wr_ready;
  logic [66*NWR-1:0] wr_data;
  logic              tx_tready;
  logic [63:0]       tx_tdata;
  logic              tx_1dw, tx_tlast, tx_tvalid;
  logic [31:0]       stat_tlps;
  logic [2:0]        dbg_state;

  logic              wv_a [NWR];
  logic [65:0]       wd_a [NWR];
  logic [65:0]       chq [NWR][$];
  logic [65:0]       exp_q [$];
  int n_cmp = 0, n_bad = 0;
  int tlps_exp = 0;
  int mptr = 0;
  int tready_mode = 1;

  pcie_tx_arb #(.NWR(NWR), .RR_LEN_DW(128), .FIFO_AW(FIFO_AW)) dut (
    .clock(clock), .reset(reset), .pcie_id(pcie_id), .rc_done(rc_done),
    .rc_dw2(rc_dw2), .rc_data(rc_data), .rr_valid(rr_valid), .rr_addr(rr_addr),
    .rr_tag(rr_tag), .rr_ready(rr_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .tx_tready(tx_tready), .tx_tdata(tx_tdata), .tx_1dw(tx_1dw),
    .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .stat_tlps(stat_tlps),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wr_valid[k]        = wv_a[k];
      wr_data[66*k +: 66] = wd_a[k];
    end
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: beat formats and arbitration order
  task automatic push_rc(input logic [31:0] d, input logic [31:0] dw2);
    exp_q.push_back({2'b00, pcie_id, 16'd8, 32'h4A000001});
    exp_q.push_back({2'b01, d[7:0], d[15:8], d[23:16], d[31:24], dw2});
    tlps_exp++;
  endtask

  task automatic push_rr(input logic [63:0] a, input logic [7:0] tag);
    logic hi;
    hi = (a[63:32] != 32'd0);
    exp_q.push_back({2'b00, pcie_id, tag, 8'hFF, 2'b00, hi, 19'd0, 10'd128});
    if (hi) exp_q.push_back({2'b01, a[31:0], a[63:32]});
    else    exp_q.push_back({2'b11, a[31:0], a[31:0]});
    tlps_exp++;
  endtask

  task automatic add_pkt(input int k, input int len);
    logic [65:0] b;
    for (int j = 0; j < len; j++) begin
      b = {1'($urandom_range(0, 1)), (j == len - 1), $urandom, $urandom};
      chq[k].push_back(b);
    end
  endtask

  // Round-robin over channels holding queued packets, starting at mptr.
  task automatic model_writes();
    int pos [NWR];
    int found;
    logic [65:0] b;
    for (int k = 0; k < NWR; k++) pos[k] = 0;
    for (int guard = 0; guard < 100; guard++) begin
      found = -1;
      for (int i = 0; i < NWR; i++) begin
        int k;
        k = (mptr + i) % NWR;
        if (found < 0 && pos[k] < chq[k].size()) found = k;
      end
      if (found < 0) break;
      do begin
        b = chq[found][pos[found]];
        pos[found]++;
        exp_q.push_back(b);
      end while (!b[64]);
      tlps_exp++;
      mptr = (found + 1) % NWR;
    end
  endtask

  // drivers
  task automatic drive_chan(input int k);
    logic acc;
    int n = 0;
    @(negedge clock);
    while (chq[k].size() > 0) begin
      wv_a[k] = 1'b1;
      wd_a[k] = chq[k][0];
      #1;
      acc = wr_ready[k];
      @(posedge clock);
      if (acc) void'(chq[k].pop_front());
      @(negedge clock);
      n++;
      if (n > 4000) begin
        check("wr_timeout", 66'(chq[k].size()), 66'd0);
        break;
      end
    end
    wv_a[k] = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, input logic [7:0] tag);
    logic acc = 1'b0;
    int n = 0;
    @(negedge clock);
    rr_valid = 1'b1;
    rr_addr  = a;
    rr_tag   = tag;
    while (!acc && n < 500) begin
      #1;
      acc = rr_ready;
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    rr_valid = 1'b0;
    if (!acc) check("rr_timeout", 66'd1, 66'd0);
  endtask

  task automatic rc_pulse(input logic [31:0] d, input logic [31:0] dw2);
    @(negedge clock);
    rc_done = 1'b1;
    rc_data = d;
    rc_dw2  = dw2;
    @(negedge clock);
    rc_done = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check("drain", 66'(exp_q.size()), 66'd0);
  endtask

  task automatic run_writes();
    model_writes();
    fork
      drive_chan(0);
      drive_chan(1);
    join
    wait_drain();
  endtask

  always begin
    @(negedge clock);
    case (tready_mode)
      0:       tx_tready = 1'b0;
      1:       tx_tready = 1'b1;
      default: tx_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) check("extra_beat", 66'd1, 66'd0);
        else check("beat", {tx_1dw, tx_tlast, tx_tdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    check("watchdog", 66'd1, 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [63:0] a;
    reset = 1'b1; pcie_id = 16'hBEEF; rc_done = 1'b0; rc_dw2 = '0; rc_data = '0;
    rr_valid = 1'b0; rr_addr = '0; rr_tag = '0;
    for (int k = 0; k < NWR; k++) begin wv_a[k] = 1'b0; wd_a[k] = '0; end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_tvalid", 66'(tx_tvalid), 66'd0);
    check("rst_rr_ready", 66'(rr_ready), 66'd0);
    check("rst_wr_ready", 66'(wr_ready), 66'd0);
    check("rst_stat", 66'(stat_tlps), 66'd0);

    // completion with known payload and tvalid latency from empty FIFO
    push_rc(32'h11223344, 32'h000000A5);
    @(negedge clock);
    rc_done = 1'b1; rc_data = 32'h11223344; rc_dw2 = 32'h000000A5;
    @(negedge clock);
    rc_done = 1'b0;
    check("lat_c0", 66'(tx_tvalid), 66'd0);
    @(negedge clock);
    check("lat_c1", 66'(tx_tvalid), 66'd0);
    @(negedge clock);
    check("lat_c2", 66'(tx_tvalid), 66'd1);
    wait_drain();

    for (int i = 0; i < 3; i++) begin
      logic [31:0] d, w;
      d = $urandom; w = $urandom;
      push_rc(d, w);
      rc_pulse(d, w);
      wait_drain();
    end

    // read requests: 32-bit and 64-bit addressing
    push_rr(64'h1000, 8'd3);
    do_read(64'h1000, 8'd3);
    push_rr(64'h1_0000_2000, 8'h5A);
    do_read(64'h1_0000_2000, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] t;
      t = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a = {32'd0, $urandom};
      else a = {32'($urandom_range(1, 32'h7FFF_FFFF)), $urandom};
      push_rr(a, t);
      do_read(a, t);
    end
    wait_drain();

    // two channels streaming 3-beat packets: grants alternate
    for (int p = 0; p < 2; p++) begin add_pkt(0, 3); add_pkt(1, 3); end
    run_writes();

    tready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NWR; k++) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 5));
      end
      run_writes();
    end
    tready_mode = 1;

    // everything requested in the same cycle: completion, read, then write
    push_rc(32'hCAFEF00D, 32'h12345678);
    push_rr(64'h0000_0000_ABCD_0000, 8'h77);
    add_pkt(0, 2);
    model_writes();
    fork
      rc_pulse(32'hCAFEF00D, 32'h12345678);
      do_read(64'h0000_0000_ABCD_0000, 8'h77);
      drive_chan(0);
    join
    wait_drain();

    // sink stalled during a long write: FIFO fills, nothing lost
    tready_mode = 0;
    add_pkt(0, 24);
    model_writes();
    fork
      drive_chan(0);
    join_none
    repeat (60) @(negedge clock);
    check("fill_ready", 66'(wr_ready[0]), 66'd0);
    check("fill_valid", 66'(tx_tvalid), 66'd1);
    check("fill_count", 66'((24 - chq[0].size()) inside {[14:16]}), 66'd1);
    tready_mode = 1;
    wait_drain();

`ifdef PCIE_TX_ARB_STATS_EN
    check("stat_tlps", 66'(stat_tlps), 66'(tlps_exp));
`else
    check("stat_tlps", 66'(stat_tlps), 66'd0);
`endif

    // reset while a completion TLP is half-written
    tready_mode = 0;
    rc_pulse(32'h55667788, 32'h99);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tlps_exp = 0;
    check("rst_mid_tvalid", 66'(tx_tvalid), 66'd0);
    check("rst_mid_stat", 66'(stat_tlps), 66'd0);
    tready_mode = 1;
    repeat (12) @(negedge clock);
    check("rst_mid_idle", 66'(tx_tvalid), 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
